approx_err_monitor: RTL

Pipelined error-statistics collector placed directly downstream of the 8-bit approximate Kogge-Stone adder. Each cycle it accepts one operand pair and the adder's 9-bit approximate sum, recomputes the exact sum, and accumulates error metrics over a run of N_SAMPLES: error count, summed error distance and maximum error distance. The host reads the final figures to derive error rate and mean error distance.

---
 rtl/approx_mon_pkg.sv | 17 +
 rtl/approx_err_dist.sv | 33 +++
 rtl/approx_err_monitor.sv | 111 +++++++++++
 3 files changed

// File: rtl/approx_mon_pkg.sv
// Shared types, widths and the saturating adder for the approximate-adder error monitor.
package approx_mon_pkg;

  localparam int unsigned OP_W = 8;
  localparam int unsigned ED_W = 9;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  // Adds inc to acc and clamps the result at lim instead of wrapping.
  function automatic logic [63:0] sat_add(input logic [63:0] acc, input logic [63:0] inc,
                                          input logic [63:0] lim);
    logic [64:0] s;
    s = {1'b0, acc} + {1'b0, inc};
    sat_add = (s > {1'b0, lim}) ? lim : s[63:0];
  endfunction

endpackage

// File: rtl/approx_err_dist.sv
// Stage 1 of the monitor: registers the exact and approximate sums, then forms |exact - approx|.
module approx_err_dist
  import approx_mon_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic [OP_W-1:0] a,
  input  logic [OP_W-1:0] b,
  input  logic [ED_W-1:0] sum_approx,
  output logic [ED_W-1:0] ed,
  output logic            ed_valid
);

  logic [ED_W-1:0] exact_q;
  logic [ED_W-1:0] approx_q;

  // Data flops carry no reset; only the valid bit matters after rst.
  always_ff @(posedge clk) begin
    if (rst) begin
      ed_valid <= 1'b0;
    end else begin
      ed_valid <= load;
      if (load) begin
        exact_q  <= ED_W'(a) + ED_W'(b);
        approx_q <= sum_approx;
      end
    end
  end

  assign ed = (exact_q >= approx_q) ? (exact_q - approx_q) : (approx_q - exact_q);

endmodule

// File: rtl/approx_err_monitor.sv
// Error-statistics collector for the approximate adder; run control FSM plus stage-2 accumulators.
// Optional max_err tracking is built only when MAX_ERR_EN is defined.
module approx_err_monitor
  import approx_mon_pkg::*;
#(
  parameter int unsigned N_SAMPLES = 256,
  parameter int unsigned ACC_W     = 20,
  parameter int unsigned CNT_W     = $clog2(N_SAMPLES + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  A,
  input  logic [OP_W-1:0]  B,
  input  logic [ED_W-1:0]  SUM_APPROX,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] sample_count,
  output logic [CNT_W-1:0] err_count,
  output logic [ACC_W-1:0] sum_err,
  output logic [ED_W-1:0]  max_err
);

  localparam logic [63:0]      ACC_MAX = (64'd1 << ACC_W) - 64'd1;
  localparam logic [CNT_W-1:0] LAST    = CNT_W'(N_SAMPLES - 1);

  state_t          state;
  logic            accept;
  logic            launch;
  logic [ED_W-1:0] ed;
  logic            ed_valid;

  assign accept = in_valid & in_ready;
  assign launch = start & ((state == IDLE) | (state == DONE));

  approx_err_dist u_dist (
    .clk        (clk),
    .rst        (rst),
    .load       (accept),
    .a          (A),
    .b          (B),
    .sum_approx (SUM_APPROX),
    .ed         (ed),
    .ed_valid   (ed_valid)
  );

  // Run control; DRAIN holds until the last sample has left stage 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      in_ready     <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      sample_count <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state        <= RUN;
            in_ready     <= 1'b1;
            busy         <= 1'b1;
            done         <= 1'b0;
            sample_count <= '0;
          end
        end
        RUN: begin
          if (accept) begin
            sample_count <= sample_count + CNT_W'(1);
            if (sample_count == LAST) begin
              state    <= DRAIN;
              in_ready <= 1'b0;
            end
          end
        end
        DRAIN: begin
          if (!ed_valid) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
      endcase
    end
  end

  // Stage-2 accumulation of error count and saturating error sum.
  always_ff @(posedge clk) begin
    if (rst || launch) begin
      err_count <= '0;
      sum_err   <= '0;
    end else if (ed_valid) begin
      if (ed != '0) err_count <= err_count + CNT_W'(1);
      sum_err <= ACC_W'(sat_add(64'(sum_err), 64'(ed), ACC_MAX));
    end
  end

`ifdef MAX_ERR_EN
  always_ff @(posedge clk) begin
    if (rst || launch) begin
      max_err <= '0;
    end else if (ed_valid && (ed > max_err)) begin
      max_err <= ed;
    end
  end
`else
  assign max_err = '0;
`endif

endmodule
